// File: rtl/vga_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_writer
//  Description : Bus-mapped pixel writer feeding the frame buffer write port.
//                Eight consecutive bus addresses starting at BASE_ADDR expose
//                X, Y, PIXEL, CTRL, FILL_W, FILL_H, FILL_GO and a reserved slot.
//                A PIXEL write produces one frame-buffer write at {Y,X} with
//                optional X/Y auto-increment. The optional rectangle-fill engine
//                writes a FILL_W x FILL_H block of one colour in row-major order,
//                one pixel per cycle, starting at the current X/Y.
//  Config      : `define VGA_FILL_EN to build the fill engine. Without it,
//                offsets +4..+6 are reserved and BUSY is tied low.
//  Ports       : CLK, RESET (sync, active-high)
//                BUS_ADDR/BUS_DATA_IN/BUS_WE      - processor write/read request
//                BUS_DATA_OUT/BUS_DATA_OE         - registered read data + valid
//                FB_ADDR {Y,X}/FB_DATA/FB_WE      - frame buffer port A write
//                BUSY                             - fill engine active
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_writer #(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         X_BITS    = 8,
    parameter int         Y_BITS    = 7,
    parameter int         PIX_BITS  = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [7:0]                 BUS_ADDR,
    input  logic [7:0]                 BUS_DATA_IN,
    input  logic                       BUS_WE,
    output logic [7:0]                 BUS_DATA_OUT,
    output logic                       BUS_DATA_OE,
    output logic [X_BITS+Y_BITS-1:0]   FB_ADDR,
    output logic [PIX_BITS-1:0]        FB_DATA,
    output logic                       FB_WE,
    output logic                       BUSY
);

    localparam logic [2:0] c_OFF_X     = 3'd0;
    localparam logic [2:0] c_OFF_Y     = 3'd1;
    localparam logic [2:0] c_OFF_PIXEL = 3'd2;
    localparam logic [2:0] c_OFF_CTRL  = 3'd3;
`ifdef VGA_FILL_EN
    localparam logic [2:0] c_OFF_FW    = 3'd4;
    localparam logic [2:0] c_OFF_FH    = 3'd5;
    localparam logic [2:0] c_OFF_GO    = 3'd6;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [X_BITS-1:0]          x_q, x_d;
    logic [Y_BITS-1:0]          y_q, y_d;
    logic                       auto_inc_q, auto_inc_d;
    logic                       fb_we_q, fb_we_d;
    logic [X_BITS+Y_BITS-1:0]   fb_addr_q, fb_addr_d;
    logic [PIX_BITS-1:0]        fb_data_q, fb_data_d;
    logic [7:0]                 bus_data_out_q, bus_data_out_d;
    logic                       bus_data_oe_q, bus_data_oe_d;

`ifdef VGA_FILL_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    fill_state_t                state_q, state_d;
    logic [7:0]                 fill_w_q, fill_w_d;
    logic [7:0]                 fill_h_q, fill_h_d;
    logic [PIX_BITS-1:0]        color_q, color_d;
    logic [7:0]                 cx_q, cx_d;
    logic [7:0]                 cy_q, cy_d;
    logic [7:0]                 w_cx_nx;
    logic [7:0]                 w_cy_nx;
    logic                       w_fill_last;
    logic [X_BITS-1:0]          w_fill_x;
    logic [Y_BITS-1:0]          w_fill_y;
`endif

    // ------------------------------------------------------------------
    // Address decode. The 9-bit upper-bound compare keeps a BASE_ADDR near
    // 8'hFF from wrapping round and aliasing low addresses into the window.
    // ------------------------------------------------------------------
    logic       w_in_range;
    logic [2:0] w_off;
    logic       w_busy;
    logic       w_wr;
    logic       w_rd;

    assign w_in_range = (BUS_ADDR >= BASE_ADDR) &&
                        ({1'b0, BUS_ADDR} < ({1'b0, BASE_ADDR} + 9'd8));
    assign w_off      = BUS_ADDR[2:0] - BASE_ADDR[2:0];
    assign w_wr       = BUS_WE && w_in_range && !w_busy;
    assign w_rd       = !BUS_WE && w_in_range;

`ifdef VGA_FILL_EN
    assign w_busy = (state_q == ST_FILL);

    // Position of the pixel following the one currently on the FB port
    assign w_fill_last = (cx_q == fill_w_q - 8'd1) && (cy_q == fill_h_q - 8'd1);
    always_comb begin
        w_cx_nx = cx_q + 8'd1;
        w_cy_nx = cy_q;
        if (cx_q == fill_w_q - 8'd1) begin
            w_cx_nx = 8'd0;
            w_cy_nx = cy_q + 8'd1;
        end
    end
    // Rectangle coordinates wrap modulo the coordinate widths
    assign w_fill_x = x_q + w_cx_nx[X_BITS-1:0];
    assign w_fill_y = y_q + w_cy_nx[Y_BITS-1:0];
`else
    assign w_busy = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        x_d            = x_q;
        y_d            = y_q;
        auto_inc_d     = auto_inc_q;
        fb_we_d        = 1'b0;
        fb_addr_d      = fb_addr_q;
        fb_data_d      = fb_data_q;
        bus_data_out_d = 8'h00;
        bus_data_oe_d  = w_rd;
`ifdef VGA_FILL_EN
        state_d        = state_q;
        fill_w_d       = fill_w_q;
        fill_h_d       = fill_h_q;
        color_d        = color_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
`endif

        // Readback, zero-extended; write-only and reserved slots read 0
        if (w_rd) begin
            case (w_off)
                c_OFF_X:    bus_data_out_d = 8'(x_q);
                c_OFF_Y:    bus_data_out_d = 8'(y_q);
                c_OFF_CTRL: bus_data_out_d = {w_busy, 6'b000000, auto_inc_q};
`ifdef VGA_FILL_EN
                c_OFF_FW:   bus_data_out_d = fill_w_q;
                c_OFF_FH:   bus_data_out_d = fill_h_q;
`endif
                default:    bus_data_out_d = 8'h00;
            endcase
        end

        if (w_wr) begin
            case (w_off)
                c_OFF_X:    x_d = BUS_DATA_IN[X_BITS-1:0];
                c_OFF_Y:    y_d = BUS_DATA_IN[Y_BITS-1:0];
                c_OFF_PIXEL: begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = {y_q, x_q};
                    fb_data_d = BUS_DATA_IN[PIX_BITS-1:0];
                    // {Y,X}+1 gives X wrap with carry into Y, Y wrapping too
                    if (auto_inc_q) begin
                        {y_d, x_d} = {y_q, x_q} + {{(X_BITS+Y_BITS-1){1'b0}}, 1'b1};
                    end
                end
                c_OFF_CTRL: auto_inc_d = BUS_DATA_IN[0];
`ifdef VGA_FILL_EN
                c_OFF_FW:   fill_w_d = BUS_DATA_IN;
                c_OFF_FH:   fill_h_d = BUS_DATA_IN;
                c_OFF_GO: begin
                    // First pixel goes out with the FILL_GO edge itself so the
                    // write burst starts the cycle BUSY rises.
                    if ((fill_w_q != 8'd0) && (fill_h_q != 8'd0)) begin
                        state_d   = ST_FILL;
                        cx_d      = 8'd0;
                        cy_d      = 8'd0;
                        color_d   = BUS_DATA_IN[PIX_BITS-1:0];
                        fb_we_d   = 1'b1;
                        fb_addr_d = {y_q, x_q};
                        fb_data_d = BUS_DATA_IN[PIX_BITS-1:0];
                    end
                end
`endif
                default: ;
            endcase
        end

`ifdef VGA_FILL_EN
        // cx/cy track the pixel currently presented on the FB port
        if (state_q == ST_FILL) begin
            if (w_fill_last) begin
                state_d = ST_IDLE;
            end else begin
                cx_d      = w_cx_nx;
                cy_d      = w_cy_nx;
                fb_we_d   = 1'b1;
                fb_addr_d = {w_fill_y, w_fill_x};
                fb_data_d = color_q;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q            <= '0;
            y_q            <= '0;
            auto_inc_q     <= 1'b0;
            fb_we_q        <= 1'b0;
            fb_addr_q      <= '0;
            fb_data_q      <= '0;
            bus_data_out_q <= 8'h00;
            bus_data_oe_q  <= 1'b0;
`ifdef VGA_FILL_EN
            state_q        <= ST_IDLE;
            fill_w_q       <= 8'h00;
            fill_h_q       <= 8'h00;
            color_q        <= '0;
            cx_q           <= 8'h00;
            cy_q           <= 8'h00;
`endif
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            auto_inc_q     <= auto_inc_d;
            fb_we_q        <= fb_we_d;
            fb_addr_q      <= fb_addr_d;
            fb_data_q      <= fb_data_d;
            bus_data_out_q <= bus_data_out_d;
            bus_data_oe_q  <= bus_data_oe_d;
`ifdef VGA_FILL_EN
            state_q        <= state_d;
            fill_w_q       <= fill_w_d;
            fill_h_q       <= fill_h_d;
            color_q        <= color_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
`endif
        end
    end

    assign BUS_DATA_OUT = bus_data_out_q;
    assign BUS_DATA_OE  = bus_data_oe_q;
    assign FB_ADDR      = fb_addr_q;
    assign FB_DATA      = fb_data_q;
    assign FB_WE        = fb_we_q;
    assign BUSY         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_writer
//  Description : Directed self-checking bench for vga_pixel_writer with
//                default parameters (BASE 0xB0, 8-bit X, 7-bit Y, 8-bit pixel).
//                Inputs change on the falling edge; outputs are checked on the
//                falling edge after the rising edge that produced them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_writer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  BUS_ADDR;
    logic [7:0]  BUS_DATA_IN;
    logic        BUS_WE;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_DATA_OE;
    logic [14:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        FB_WE;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    vga_pixel_writer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUS_ADDR     (BUS_ADDR),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_WE       (BUS_WE),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .BUS_DATA_OE  (BUS_DATA_OE),
        .FB_ADDR      (FB_ADDR),
        .FB_DATA      (FB_DATA),
        .FB_WE        (FB_WE),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Both tasks start and end on a falling edge; the bus parks at 0x00
    // (outside the decoded window) between operations.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR    = a;
        BUS_DATA_IN = d;
        BUS_WE      = 1'b1;
        @(negedge CLK);
        BUS_WE      = 1'b0;
        BUS_ADDR    = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a);
        BUS_ADDR = a;
        BUS_WE   = 1'b0;
        @(negedge CLK);
        BUS_ADDR = 8'h00;
    endtask

    initial begin
        logic [14:0] exp_addr [6];
        exp_addr[0] = 15'h05FE; exp_addr[1] = 15'h05FF; exp_addr[2] = 15'h0500;
        exp_addr[3] = 15'h06FE; exp_addr[4] = 15'h06FF; exp_addr[5] = 15'h0600;

        RESET = 1'b1; BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00; BUS_WE = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Reset state
        chk("rst_fb_we",   FB_WE, 1'b0);
        chk("rst_fb_addr", FB_ADDR, 15'h0000);
        chk("rst_fb_data", FB_DATA, 8'h00);
        chk("rst_bus_out", BUS_DATA_OUT, 8'h00);
        chk("rst_bus_oe",  BUS_DATA_OE, 1'b0);
        chk("rst_busy",    BUSY, 1'b0);

        // All eight offsets read zero after reset, OE for one cycle each
        for (int i = 0; i < 8; i++) begin
            rd(8'hB0 + i[7:0]);
            chk("rd_rst_data", BUS_DATA_OUT, 8'h00);
            chk("rd_rst_oe",   BUS_DATA_OE, 1'b1);
            @(negedge CLK);
            chk("rd_rst_oe_drop", BUS_DATA_OE, 1'b0);
        end

        // Out-of-range reads on both sides of the window
        rd(8'hB8);
        chk("rd_oob_hi_oe", BUS_DATA_OE, 1'b0);
        rd(8'hAF);
        chk("rd_oob_lo_oe", BUS_DATA_OE, 1'b0);

        // Plain pixel write, no auto-increment
        wr(8'hB0, 8'h12);
        wr(8'hB1, 8'h34);
        wr(8'hB2, 8'hE0);
        chk("pix_we",   FB_WE, 1'b1);
        chk("pix_addr", FB_ADDR, 15'h3412);
        chk("pix_data", FB_DATA, 8'hE0);
        @(negedge CLK);
        chk("pix_we_drop", FB_WE, 1'b0);
        rd(8'hB0);
        chk("pix_x_keep", BUS_DATA_OUT, 8'h12);
        rd(8'hB1);
        chk("pix_y_keep", BUS_DATA_OUT, 8'h34);

        // Y register is 7 bits wide: upper bit dropped on write
        wr(8'hB1, 8'hFF);
        rd(8'hB1);
        chk("y_trunc", BUS_DATA_OUT, 8'h7F);

        // Auto-increment across the X and Y wrap, back-to-back writes
        wr(8'hB3, 8'h01);
        rd(8'hB3);
        chk("ctrl_rd", BUS_DATA_OUT, 8'h01);
        wr(8'hB0, 8'hFF);
        wr(8'hB1, 8'h7F);
        wr(8'hB2, 8'hAA);
        chk("ai_we0",   FB_WE, 1'b1);
        chk("ai_addr0", FB_ADDR, 15'h7FFF);
        chk("ai_data0", FB_DATA, 8'hAA);
        wr(8'hB2, 8'h55);
        chk("ai_we1",   FB_WE, 1'b1);
        chk("ai_addr1", FB_ADDR, 15'h0000);
        chk("ai_data1", FB_DATA, 8'h55);
        rd(8'hB0);
        chk("ai_x_after", BUS_DATA_OUT, 8'h01);
        rd(8'hB1);
        chk("ai_y_after", BUS_DATA_OUT, 8'h00);

        // Writes outside the window are ignored
        wr(8'hB8, 8'h99);
        wr(8'hAF, 8'h77);
        rd(8'hB0);
        chk("oob_wr_x", BUS_DATA_OUT, 8'h01);

`ifdef VGA_FILL_EN
        // 3x2 fill wrapping across X, with a dropped PIXEL write and a
        // CTRL read in the middle of the burst
        wr(8'hB3, 8'h00);
        wr(8'hB0, 8'hFE);
        wr(8'hB1, 8'h05);
        wr(8'hB4, 8'h03);
        wr(8'hB5, 8'h02);
        rd(8'hB4);
        chk("fw_rd", BUS_DATA_OUT, 8'h03);
        wr(8'hB6, 8'h1C);
        for (int k = 0; k < 6; k++) begin
            chk("fill_we",   FB_WE, 1'b1);
            chk("fill_addr", FB_ADDR, exp_addr[k]);
            chk("fill_data", FB_DATA, 8'h1C);
            chk("fill_busy", BUSY, 1'b1);
            if (k == 3) begin
                chk("fill_ctrl_rd", BUS_DATA_OUT, 8'h80);
                chk("fill_ctrl_oe", BUS_DATA_OE, 1'b1);
            end
            if (k == 1) begin
                BUS_ADDR = 8'hB2; BUS_DATA_IN = 8'hFF; BUS_WE = 1'b1;
            end else if (k == 2) begin
                BUS_ADDR = 8'hB3; BUS_WE = 1'b0;
            end else begin
                BUS_ADDR = 8'h00; BUS_WE = 1'b0;
            end
            @(negedge CLK);
        end
        BUS_ADDR = 8'h00; BUS_WE = 1'b0;
        chk("fill_end_we",   FB_WE, 1'b0);
        chk("fill_end_busy", BUSY, 1'b0);
        rd(8'hB0);
        chk("fill_x_keep", BUS_DATA_OUT, 8'hFE);

        // Single-pixel fill
        wr(8'hB4, 8'h01);
        wr(8'hB5, 8'h01);
        wr(8'hB6, 8'h42);
        chk("fill1_we",   FB_WE, 1'b1);
        chk("fill1_addr", FB_ADDR, 15'h05FE);
        chk("fill1_busy", BUSY, 1'b1);
        @(negedge CLK);
        chk("fill1_end_we",   FB_WE, 1'b0);
        chk("fill1_end_busy", BUSY, 1'b0);

        // Zero width: no writes, never busy
        wr(8'hB4, 8'h00);
        wr(8'hB6, 8'h33);
        chk("fw0_we",   FB_WE, 1'b0);
        chk("fw0_busy", BUSY, 1'b0);
        @(negedge CLK);
        chk("fw0_we2",   FB_WE, 1'b0);
        chk("fw0_busy2", BUSY, 1'b0);

        // Reset on the third write of a fill aborts it
        wr(8'hB4, 8'h03);
        wr(8'hB6, 8'h1C);
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_third_we", FB_WE, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_we",   FB_WE, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_we2", FB_WE, 1'b0);
        rd(8'hB0);
        chk("abort_x", BUS_DATA_OUT, 8'h00);
`else
        // Fill offsets behave as reserved in this build
        wr(8'hB4, 8'h05);
        rd(8'hB4);
        chk("nofill_fw_rd", BUS_DATA_OUT, 8'h00);
        wr(8'hB6, 8'h11);
        chk("nofill_go_we",   FB_WE, 1'b0);
        chk("nofill_go_busy", BUSY, 1'b0);
        rd(8'hB3);
        chk("nofill_ctrl", BUS_DATA_OUT, 8'h01);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        rd(8'hB0);
        chk("reset_x", BUS_DATA_OUT, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pixel_writer.md
# vga_pixel_writer

Parametrised bus-mapped pixel writer between the 8-bit processor bus and the dual-port frame buffer write port. It replaces the fixed X-then-Y-then-pixel write sequence with independently addressable registers, register readback, optional X/Y auto-increment, and an optional rectangle-fill engine. Output drives frame buffer port A directly; the VGA read side is unchanged.

## Interface
Parameters:
- BASE_ADDR, 8'hB0, first of 8 consecutive bus addresses decoded.
- X_BITS, 8, X coordinate width (1..8).
- Y_BITS, 7, Y coordinate width (1..8).
- PIX_BITS, 8, pixel data width (1..8).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- BUS_ADDR  in  8  processor address.
- BUS_DATA_IN  in  8  processor write data.
- BUS_WE  in  1  write strobe, one cycle per write.
- BUS_DATA_OUT  out  8  read data, zero-extended.
- BUS_DATA_OE  out  1  high when BUS_DATA_OUT carries valid read data.
- FB_ADDR  out  X_BITS+Y_BITS  frame buffer address {Y, X}.
- FB_DATA  out  PIX_BITS  frame buffer write data.
- FB_WE  out  1  frame buffer write enable.
- BUSY  out  1  fill engine active.

## Operation
Register map (offset from BASE_ADDR):
- +0 X (R/W), +1 Y (R/W), +2 PIXEL (W: write at current X,Y), +3 CTRL (R/W; bit0 AUTO_INC, bit7 BUSY read-only), +4 FILL_W (R/W), +5 FILL_H (R/W), +6 FILL_GO (W: data = fill colour, starts fill), +7 reserved (reads 0, writes ignored).
- Writes truncate BUS_DATA_IN to register width; reads zero-extend.
- PIXEL write: FB_ADDR={Y,X}, FB_DATA=data[PIX_BITS-1:0], FB_WE=1 for one cycle.
- AUTO_INC=1: after a PIXEL write X<=X+1 mod 2^X_BITS; on X wrap, Y<=Y+1 mod 2^Y_BITS. AUTO_INC=0: X,Y unchanged.
- Fill states IDLE, FILL. FILL_GO in IDLE -> FILL with cx=0, cy=0; each cycle writes colour at {(Y+cy) mod 2^Y_BITS, (X+cx) mod 2^X_BITS}; cx increments, at cx=FILL_W-1 cx<=0 and cy increments; after cx=FILL_W-1, cy=FILL_H-1 -> IDLE. Total exactly FILL_W*FILL_H writes, row-major.
- FILL_W=0 or FILL_H=0: FILL_GO produces no writes, stays IDLE.
- While BUSY: writes to +0..+6 ignored (dropped, no queueing); reads still served. X/Y not modified by fill.
- Accesses outside BASE_ADDR..BASE_ADDR+7 ignored; BUS_DATA_OE stays 0.

## Timing
- Reset values: X=0, Y=0, CTRL=0, FILL_W=0, FILL_H=0, state IDLE, FB_WE=0, FB_ADDR=0, FB_DATA=0, BUS_DATA_OUT=0, BUS_DATA_OE=0, BUSY=0.
- Register write: visible one cycle after the BUS_WE cycle.
- PIXEL write at cycle n: FB_WE=1 in cycle n+1 only, with FB_ADDR/FB_DATA from X/Y before auto-increment.
- Back-to-back PIXEL writes: one FB write per cycle, no stalls.
- Read (BUS_WE=0, address in range) at cycle n: BUS_DATA_OUT valid and BUS_DATA_OE=1 in cycle n+1 only.
- FILL_GO at cycle n: BUSY=1 and first FB_WE in cycle n+1; FB_WE high continuously for W*H cycles; BUSY falls in the cycle after the last write.
- RESET mid-fill: abort; FB_WE=0 and BUSY=0 from the next edge.
- Write and read the same cycle impossible (single BUS_WE); X write coinciding with auto-increment cannot occur (one bus op per cycle).

## Configuration
- VGA_FILL_EN defined: fill engine, FILL_W/FILL_H/FILL_GO registers and BUSY as specified.
- Undefined: offsets +4..+6 behave as reserved (read 0, writes ignored); BUSY tied 0; CTRL bit7 reads 0.

## Test plan
- Reset, then read all 8 offsets -> all return 0x00, BUS_DATA_OE one cycle each.
- X=0x12, Y=0x34, PIXEL=0xE0 (AUTO_INC=0) -> one FB_WE cycle, FB_ADDR=15'h3412, FB_DATA=0xE0; X/Y reread 0x12/0x34.
- AUTO_INC=1, X=0xFF, Y=0x7F, PIXEL twice -> writes at 15'h7FFF then 15'h0000; X=0x01, Y=0x00 after.
- VGA_FILL_EN: X=0xFE, Y=5, W=3, H=2, FILL_GO=0x1C -> 6 consecutive writes at {5,FE},{5,FF},{5,00},{6,FE},{6,FF},{6,00}, data 0x1C; BUSY high 6 cycles; PIXEL write during fill produces no extra write.
- FILL_W=0, FILL_GO -> no FB_WE, BUSY stays 0.
- RESET asserted on third fill write -> FB_WE=0, BUSY=0 next cycle; X reads 0.
